// File: rtl/uart_rx_sipo_param.sv
// Parametrised UART receiver. It validates the start bit on an oversampled line and takes a
// 3-sample majority for each bit, then checks parity and framing into a valid/ready holding register.
module uart_rx_sipo_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  localparam int FRAME_W   = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 data_tx,
  input  logic                 rx_en,
  input  logic                 data_ready,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic [FRAME_W-1:0]   frame_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 active_flag
);

  localparam int H      = OVERSAMPLE / 2;
  localparam int TW     = $clog2(OVERSAMPLE);
  localparam int NSHIFT = DATA_BITS + ((PARITY != 0) ? 1 : 0);
  localparam int BW     = $clog2(NSHIFT + 1);

  localparam logic [TW-1:0] T_S0   = TW'(H - 1);
  localparam logic [TW-1:0] T_S1   = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NSHIFT - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic f_par_err(input logic [DATA_BITS:0] dp);
    logic w_x;
    w_x = ^dp;
    case (2'(PARITY))
      2'd0:    f_par_err = 1'b0;
      2'd1:    f_par_err = w_x;
      2'd2:    f_par_err = ~w_x;
      default: f_par_err = 1'b0;
    endcase
  endfunction

  function automatic logic f_stop_err(input logic [STOP_BITS-1:0] st);
    f_stop_err = ~(&st);
  endfunction

  state_t                 r_state;
  state_t                 w_next_state;
  logic [1:0]             r_sync;
  logic [TW-1:0]          r_tick;
  logic [TW-1:0]          w_tick_nxt;
  logic [BW-1:0]          r_bit;
  logic [BW-1:0]          w_bit_nxt;
  logic                   r_stop;
  logic                   w_stop_nxt;
  logic                   r_s0;
  logic                   r_s1;
  logic [FRAME_W-2:0]     r_shift;
  logic                   w_shift_en;
  logic                   w_done;
  logic                   w_rxs;
  logic                   w_maj;
  logic [FRAME_W-1:0]     w_frame_nxt;
  logic                   r_valid;
  logic [DATA_BITS-1:0]   r_data;
  logic [FRAME_W-1:0]     r_frame;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_brk;
  logic                   r_ovr;
  logic                   r_active;

  assign w_rxs       = r_sync[1];
  // Third sample is the live synchronised line at the decision tick.
  assign w_maj       = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_frame_nxt = {w_maj, r_shift};

  // Next-state, bit-timing counters and shift/complete strobes.
  always_comb begin
    w_next_state = r_state;
    w_tick_nxt   = r_tick + TW'(1);
    w_bit_nxt    = r_bit;
    w_stop_nxt   = r_stop;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_nxt = '0;
        w_bit_nxt  = '0;
        w_stop_nxt = 1'b0;
        if (rx_en && !w_rxs) w_next_state = START;
        else                 w_next_state = IDLE;
      end
      START: begin
        if (!rx_en)                        w_next_state = IDLE;
        else if (r_tick == T_DEC && w_maj) w_next_state = IDLE;
        else if (r_tick == T_DEC)          w_shift_en   = 1'b1;
        else if (r_tick == T_LAST) begin
          w_next_state = SHIFT;
          w_tick_nxt   = '0;
          w_bit_nxt    = '0;
        end else begin
          w_next_state = START;
        end
      end
      SHIFT: begin
        if (!rx_en)               w_next_state = IDLE;
        else if (r_tick == T_DEC) w_shift_en   = 1'b1;
        else if (r_tick == T_LAST) begin
          w_tick_nxt = '0;
          if (r_bit == B_LAST) begin
            w_next_state = STOP;
            w_stop_nxt   = 1'b0;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_next_state = SHIFT;
        end
      end
      STOP: begin
        if (!rx_en) w_next_state = IDLE;
        else if (r_tick == T_DEC) begin
          w_shift_en = 1'b1;
          // Leave on the final stop decision so a following start edge is not missed.
          if (r_stop == S_LAST) begin
            w_next_state = IDLE;
            w_done       = 1'b1;
          end else begin
            w_next_state = STOP;
          end
        end else if (r_tick == T_LAST) begin
          w_tick_nxt = '0;
          w_stop_nxt = ~r_stop;
        end else begin
          w_next_state = STOP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Receive datapath: synchroniser, FSM state, counters, samples and shift register.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sync   <= 2'b11;
      r_tick   <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_s0     <= 1'b1;
      r_s1     <= 1'b1;
      r_shift  <= '1;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_sync   <= {r_sync[0], data_tx};
      r_tick   <= w_tick_nxt;
      r_bit    <= w_bit_nxt;
      r_stop   <= w_stop_nxt;
      r_active <= (w_next_state != IDLE);
      if (r_tick == T_S0) r_s0 <= w_rxs;
      if (r_tick == T_S1) r_s1 <= w_rxs;
      if (w_shift_en) r_shift <= w_frame_nxt[FRAME_W-1:1];
    end
  end

  // Holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_frame <= '1;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && (!r_valid || data_ready)) begin
        r_valid <= 1'b1;
        r_data  <= w_frame_nxt[DATA_BITS:1];
        r_frame <= w_frame_nxt;
        r_perr  <= f_par_err(w_frame_nxt[DATA_BITS+1:1]);
        r_ferr  <= f_stop_err(w_frame_nxt[FRAME_W-1 -: STOP_BITS]);
        r_brk   <= (w_frame_nxt == '0);
      end else if (w_done) begin
        r_ovr <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_valid  = r_valid;
  assign data_out    = r_data;
  assign frame_out   = r_frame;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign break_det   = r_brk;
  assign overrun_err = r_ovr;
  assign active_flag = r_active;

endmodule

// File: tb/tb_uart_rx_sipo_param.sv
// Directed bench for uart_rx_sipo_param: default configuration plus a 7-bit/odd/2-stop/8x instance.
module tb_uart_rx_sipo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tx_a, en_a, rdy_a, dv_a, perr_a, ferr_a, brk_a, ovr_a, act_a;
  logic [7:0]  dout_a;
  logic [10:0] frame_a;
  logic tx_b, en_b, rdy_b, dv_b, perr_b, ferr_b, brk_b, ovr_b, act_b;
  logic [6:0]  dout_b;
  logic [10:0] frame_b;

  uart_rx_sipo_param dut_a (
    .baud_clk(clk), .reset(rst), .data_tx(tx_a), .rx_en(en_a), .data_ready(rdy_a),
    .data_valid(dv_a), .data_out(dout_a), .frame_out(frame_a), .parity_err(perr_a),
    .frame_err(ferr_a), .break_det(brk_a), .overrun_err(ovr_a), .active_flag(act_a)
  );

  uart_rx_sipo_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(8)) dut_b (
    .baud_clk(clk), .reset(rst), .data_tx(tx_b), .rx_en(en_b), .data_ready(rdy_b),
    .data_valid(dv_b), .data_out(dout_b), .frame_out(frame_b), .parity_err(perr_b),
    .frame_err(ferr_b), .break_det(brk_b), .overrun_err(ovr_b), .active_flag(act_b)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: delivery capture on data_valid rise, pulse and activity counters.
  int start_a = 0, start_b = 0;
  int dlv_a = 0, lat_a = 0, ovr_cnt_a = 0, act_cnt_a = 0;
  int dlv_b = 0, lat_b = 0, ovr_cnt_b = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  logic [7:0]  cd_a;
  logic [10:0] cf_a;
  logic cp_a, ce_a, cb_a;

  always @(negedge clk) begin
    pv_a <= dv_a;
    if (dv_a && !pv_a) begin
      dlv_a <= dlv_a + 1;
      lat_a <= cyc - start_a - 1;
      cd_a  <= dout_a;
      cf_a  <= frame_a;
      cp_a  <= perr_a;
      ce_a  <= ferr_a;
      cb_a  <= brk_a;
    end
    if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
    if (act_a) act_cnt_a <= act_cnt_a + 1;
  end

  always @(negedge clk) begin
    pv_b <= dv_b;
    if (dv_b && !pv_b) begin
      dlv_b <= dlv_b + 1;
      lat_b <= cyc - start_b - 1;
    end
    if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive an 11-bit raw frame LSB first; optional tick-H noise and rx_en abort (instance A only).
  task automatic send(input bit sel_b, input logic [10:0] fr, input int os, input bit noise,
                      input int abort_at);
    logic v;
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < os; j++) begin
        v = fr[k];
        if (noise && j == os / 2 + 1) v = ~v;
        if (sel_b) tx_b = v;
        else       tx_a = v;
        if (k == 0 && j == 0) begin
          if (sel_b) start_b = cyc;
          else       start_a = cyc;
        end
        if (k == abort_at && j == os / 2) begin
          check_eq("abort_active_before", {31'd0, act_a}, 32'd1);
          en_a = 1'b0;
        end
        @(negedge clk);
        if (k == abort_at && j == os / 2) check_eq("abort_active_after", {31'd0, act_a}, 32'd0);
      end
    end
    if (sel_b) tx_b = 1'b1;
    else       tx_a = 1'b1;
  endtask

  int d0, a0, o0;

  initial begin
    rst = 1'b1; tx_a = 1'b1; tx_b = 1'b1; en_a = 1'b1; en_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    idle(3);
    check_eq("rst_valid",  {31'd0, dv_a},    32'd0);
    check_eq("rst_data",   {24'd0, dout_a},  32'd0);
    check_eq("rst_frame",  {21'd0, frame_a}, 32'h7FF);
    check_eq("rst_errs",   {29'd0, perr_a, ferr_a, brk_a}, 32'd0);
    check_eq("rst_ovr",    {31'd0, ovr_a},   32'd0);
    check_eq("rst_active", {31'd0, act_a},   32'd0);
    rst = 1'b0;
    idle(4);

    // 0xA5, even parity 0, stop 1, consumer ready
    rdy_a = 1'b1; d0 = dlv_a;
    send(1'b0, 11'h54A, 16, 1'b0, -1);
    idle(20);
    check_eq("a5_count",   dlv_a - d0, 32'd1);
    check_eq("a5_latency", lat_a, 32'd172);
    check_eq("a5_data",    {24'd0, cd_a}, 32'hA5);
    check_eq("a5_frame",   {21'd0, cf_a}, 32'h54A);
    check_eq("a5_errs",    {29'd0, cp_a, ce_a, cb_a}, 32'd0);
    check_eq("a5_handshake_drop", {31'd0, dv_a}, 32'd0);

    // 4-cycle low glitch: false start
    a0 = act_cnt_a; d0 = dlv_a;
    tx_a = 1'b0; idle(4); tx_a = 1'b1;
    idle(30);
    check_eq("glitch_active_cycles", act_cnt_a - a0, 32'd10);
    check_eq("glitch_no_delivery",   dlv_a - d0, 32'd0);
    check_eq("glitch_valid",         {31'd0, dv_a}, 32'd0);

    // 0x3C with wrong parity bit 1
    d0 = dlv_a;
    send(1'b0, {1'b1, 1'b1, 8'h3C, 1'b0}, 16, 1'b0, -1);
    idle(30);
    check_eq("par_count", dlv_a - d0, 32'd1);
    check_eq("par_data",  {24'd0, cd_a}, 32'h3C);
    check_eq("par_errs",  {29'd0, cp_a, ce_a, cb_a}, 32'b100);

    // 0x81 with stop bit 0
    d0 = dlv_a;
    send(1'b0, {1'b0, 1'b0, 8'h81, 1'b0}, 16, 1'b0, -1);
    idle(30);
    check_eq("stop_count", dlv_a - d0, 32'd1);
    check_eq("stop_data",  {24'd0, cd_a}, 32'h81);
    check_eq("stop_errs",  {29'd0, cp_a, ce_a, cb_a}, 32'b010);

    // Overrun: consumer stalled, 0x11 then 0x22
    rdy_a = 1'b0;
    send(1'b0, {1'b1, 1'b0, 8'h11, 1'b0}, 16, 1'b0, -1);
    idle(10);
    check_eq("ovr_first_valid", {31'd0, dv_a}, 32'd1);
    check_eq("ovr_first_data",  {24'd0, dout_a}, 32'h11);
    o0 = ovr_cnt_a;
    send(1'b0, {1'b1, 1'b0, 8'h22, 1'b0}, 16, 1'b0, -1);
    idle(10);
    check_eq("ovr_pulse_cycles", ovr_cnt_a - o0, 32'd1);
    check_eq("ovr_data_kept",    {24'd0, dout_a}, 32'h11);
    check_eq("ovr_valid_kept",   {31'd0, dv_a}, 32'd1);
    rdy_a = 1'b1; idle(1); rdy_a = 1'b0; idle(1);
    check_eq("ovr_valid_drop", {31'd0, dv_a}, 32'd0);

    // Break: line low for about two frame times
    rdy_a = 1'b1; d0 = dlv_a;
    tx_a = 1'b0; idle(344); tx_a = 1'b1;
    idle(40);
    check_eq("brk_count", dlv_a - d0, 32'd2);
    check_eq("brk_data",  {24'd0, cd_a}, 32'd0);
    check_eq("brk_frame", {21'd0, cf_a}, 32'd0);
    check_eq("brk_errs",  {29'd0, cp_a, ce_a, cb_a}, 32'b011);

    // rx_en dropped during data bit 3
    d0 = dlv_a;
    send(1'b0, {1'b1, 1'b0, 8'h5A, 1'b0}, 16, 1'b0, 4);
    idle(10);
    en_a = 1'b1;
    idle(10);
    check_eq("abort_no_delivery", dlv_a - d0, 32'd0);
    check_eq("abort_valid",       {31'd0, dv_a}, 32'd0);
    check_eq("abort_idle",        {31'd0, act_a}, 32'd0);

    // 7 data bits, odd parity, 2 stops, 8x, noise on each tick H
    d0 = dlv_b; o0 = ovr_cnt_b;
    send(1'b1, 11'h7AA, 8, 1'b1, -1);
    idle(10);
    check_eq("b_count",   dlv_b - d0, 32'd1);
    check_eq("b_latency", lat_b, 32'd88);
    check_eq("b_valid",   {31'd0, dv_b}, 32'd1);
    check_eq("b_data",    {25'd0, dout_b}, 32'h55);
    check_eq("b_frame",   {21'd0, frame_b}, 32'h7AA);
    check_eq("b_errs",    {29'd0, perr_b, ferr_b, brk_b}, 32'd0);
    check_eq("b_no_ovr",  ovr_cnt_b - o0, 32'd0);
    check_eq("b_idle",    {31'd0, act_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
